mtf_tracker: RTL and testbench
==============================

Name: mtf_tracker

Overview:
- Parametrised move-to-front (MRU-ordered) tag list with DEPTH entries of WIDTH bits.
- Each accepted input is looked up against all valid entries:
  - Hit: the entry moves to slot 0.
  - Miss: the input is inserted at slot 0, everything shifts down, and the oldest entry is evicted.
- Reports hit/miss, hit index, evicted tag and occupancy, one cycle after acceptance.
- Intended as the recency/replacement tracker in front of small caches and lookup tables.

Parameters:
- WIDTH, 8, tag width in bits.
- DEPTH, 4, number of list entries (>=2).
- IDX_W, $clog2(DEPTH), width of the index field.
- CNT_W, 16, width of the statistics counters (optional feature).

Ports:
- clk_in  input  1  clock, all logic on rising edge.
- rst_in  input  1  synchronous, active-high reset.
- in_valid  input  1  data_in is valid this cycle (always accepted, no backpressure).
- data_in  input  WIDTH  tag to look up / insert.
- flush_in  input  1  invalidate all entries.
- out  output  DEPTH*WIDTH  entry contents; slot k at bits [k*WIDTH +: WIDTH]; slot 0 = most recent.
- out_valid  output  DEPTH  per-slot valid bit.
- count_out  output  IDX_W+1  number of valid entries.
- hit_out  output  1  one-cycle pulse: previous accepted input hit.
- miss_out  output  1  one-cycle pulse: previous accepted input missed.
- hit_idx_out  output  IDX_W  slot index where the hit was found; 0 when hit_out is low.
- evict_valid_out  output  1  one-cycle pulse: a valid entry was pushed out.
- evict_data_out  output  WIDTH  evicted tag; 0 when evict_valid_out is low.
- hit_cnt_out  output  CNT_W  total hits (optional feature).
- miss_cnt_out  output  CNT_W  total misses (optional feature).

Behaviour:
- Reset: while rst_in=1 at an edge, all of the following are 0: out, out_valid, count_out, all pulses, hit_idx_out, evict_data_out, and the counters. Reset mid-operation discards everything; in_valid and flush_in are ignored that cycle.
- Valid bits are always contiguous from slot 0 (thermometer code); count_out equals the popcount of out_valid.
- Compare: match[k] = out_valid[k] & (out[k] == data_in). Invalid slots never match, including when data_in equals the stale/zero contents.
- Duplicates cannot arise by construction. If multiple matches occur anyway, the lowest index wins.
- Accept (in_valid=1, flush_in=0, rst_in=0):
  - Hit at k:
    - Slots 0..k-1 shift to 1..k; slot 0 <= data_in; slots >k unchanged; out_valid unchanged.
    - Next cycle: hit_out=1, hit_idx_out=k.
    - Hit at k=0 leaves the contents unchanged.
  - Miss:
    - All slots shift down by one; slot 0 <= data_in; out_valid <= {out_valid[DEPTH-2:0],1}.
    - If out_valid[DEPTH-1] was 1: next cycle evict_valid_out=1 and evict_data_out = old slot DEPTH-1. count_out stays at DEPTH.
    - Next cycle: miss_out=1.
- Idle (in_valid=0): list holds; all pulses are 0 the next cycle.
- flush_in=1 (rst_in=0):
  - out_valid <= 0, count_out <= 0; out contents hold.
  - Takes priority over in_valid: the same-cycle input is dropped, no pulses next cycle, counters not updated.
- Latency:
  - List state (out, out_valid, count_out) updates at the edge that accepts the input.
  - Result pulses appear in the following cycle, aligned with the updated list.
  - Back-to-back inputs are supported every cycle.
  - Lookup is always against the registered list state, so an input in cycle n+1 sees the list already updated by the input of cycle n.

Optional Feature:
- Macro: MTF_TRACKER_STATS_EN.
- Defined:
  - hit_cnt_out and miss_cnt_out increment by 1 per accepted hit / miss, at the same edge the list updates.
  - Counters saturate at 2^CNT_W-1.
  - Cleared only by reset; flush does not clear them.
- Undefined: both ports are present and tied to 0; no counter logic is synthesised.

Test Plan (WIDTH=8, DEPTH=4):
1. Reset, then insert 0x11, 0x22, 0x33 on consecutive cycles -> out slots 0..2 = 0x33, 0x22, 0x11; out_valid=4'b0111; count_out=3; three miss_out pulses; no evict.
2. Continue with 0x44, then 0x55 -> out = 0x55, 0x44, 0x33, 0x22; out_valid=4'b1111; on the 0x55 result cycle evict_valid_out=1, evict_data_out=0x11.
3. List 0x55, 0x44, 0x33, 0x22; insert 0x33 -> out = 0x33, 0x55, 0x44, 0x22; hit_out=1, hit_idx_out=2; out_valid unchanged. Then insert 0x33 again -> hit_idx_out=0, contents unchanged.
4. After reset, insert 0x00 -> miss_out=1 (no match on invalid zeroed slots); slot 0=0x00, count_out=1.
5. Full list; flush_in=1 with in_valid=1, data_in=0x77 -> out_valid=0, count_out=0, no pulses. Next insert 0x77 -> miss. Also assert rst_in mid-stream -> all outputs 0 at the next cycle.
6. With MTF_TRACKER_STATS_EN, CNT_W=2: run 5 misses and 1 hit -> miss_cnt_out saturates at 3, hit_cnt_out=1. Without the macro, both read 0 throughout.

Source files
------------

// File: rtl/mtf_tracker.sv
// ============================================================================
// Module   : mtf_tracker
// Brief    : Move-to-front (MRU-ordered) tag list with hit/miss/evict reporting.
//            Optional hit/miss statistics counters enabled by MTF_TRACKER_STATS_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mtf_tracker #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int IDX_W = $clog2(DEPTH),
    parameter int CNT_W = 16
) (
    input  logic                   clk_in,
    input  logic                   rst_in,
    input  logic                   in_valid,
    input  logic [WIDTH-1:0]       data_in,
    input  logic                   flush_in,
    output logic [DEPTH*WIDTH-1:0] out,
    output logic [DEPTH-1:0]       out_valid,
    output logic [IDX_W:0]         count_out,
    output logic                   hit_out,
    output logic                   miss_out,
    output logic [IDX_W-1:0]       hit_idx_out,
    output logic                   evict_valid_out,
    output logic [WIDTH-1:0]       evict_data_out,
    output logic [CNT_W-1:0]       hit_cnt_out,
    output logic [CNT_W-1:0]       miss_cnt_out
);

    localparam logic [IDX_W:0] C_FULL = (IDX_W+1)'(DEPTH);

    logic [WIDTH-1:0] r_slot     [DEPTH];
    logic [WIDTH-1:0] w_slot_nxt [DEPTH];
    logic [DEPTH-1:0] r_valid;
    logic [IDX_W:0]   r_count;
    logic [DEPTH-1:0] w_match;
    logic [DEPTH-1:1] w_shift;
    logic             w_hit;
    logic [IDX_W-1:0] w_hit_idx;

    logic             r_hit;
    logic             r_miss;
    logic [IDX_W-1:0] r_hit_idx;
    logic             r_evict_valid;
    logic [WIDTH-1:0] r_evict_data;

    // A slot shifts down exactly when no lower slot matched, which covers both
    // the partial rotate on a hit and the full shift on a miss.
    always_comb begin : comb_lookup
        logic v_seen;
        w_match   = '0;
        w_shift   = '0;
        w_hit_idx = '0;
        for (int k = 0; k < DEPTH; k++) begin
            w_match[k] = r_valid[k] && (r_slot[k] == data_in);
        end
        for (int k = DEPTH-1; k >= 0; k--) begin
            if (w_match[k]) begin
                w_hit_idx = IDX_W'(k);
            end
        end
        w_hit  = |w_match;
        v_seen = w_match[0];
        for (int k = 1; k < DEPTH; k++) begin
            w_shift[k] = ~v_seen;
            v_seen     = v_seen | w_match[k];
        end
        for (int k = 0; k < DEPTH; k++) begin
            w_slot_nxt[k] = r_slot[k];
        end
        w_slot_nxt[0] = data_in;
        for (int k = 1; k < DEPTH; k++) begin
            if (w_shift[k]) begin
                w_slot_nxt[k] = r_slot[k-1];
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            for (int k = 0; k < DEPTH; k++) begin
                r_slot[k] <= '0;
            end
            r_valid       <= '0;
            r_count       <= '0;
            r_hit         <= 1'b0;
            r_miss        <= 1'b0;
            r_hit_idx     <= '0;
            r_evict_valid <= 1'b0;
            r_evict_data  <= '0;
        end else begin
            r_hit         <= 1'b0;
            r_miss        <= 1'b0;
            r_hit_idx     <= '0;
            r_evict_valid <= 1'b0;
            r_evict_data  <= '0;
            if (flush_in) begin
                r_valid <= '0;
                r_count <= '0;
            end else if (in_valid) begin
                for (int k = 0; k < DEPTH; k++) begin
                    r_slot[k] <= w_slot_nxt[k];
                end
                if (w_hit) begin
                    r_hit     <= 1'b1;
                    r_hit_idx <= w_hit_idx;
                end else begin
                    r_miss  <= 1'b1;
                    r_valid <= {r_valid[DEPTH-2:0], 1'b1};
                    if (r_count != C_FULL) begin
                        r_count <= r_count + 1'b1;
                    end
                    if (r_valid[DEPTH-1]) begin
                        r_evict_valid <= 1'b1;
                        r_evict_data  <= r_slot[DEPTH-1];
                    end
                end
            end
        end
    end

    generate
        for (genvar g = 0; g < DEPTH; g++) begin : g_out
            assign out[g*WIDTH +: WIDTH] = r_slot[g];
        end
    endgenerate

    assign out_valid       = r_valid;
    assign count_out       = r_count;
    assign hit_out         = r_hit;
    assign miss_out        = r_miss;
    assign hit_idx_out     = r_hit_idx;
    assign evict_valid_out = r_evict_valid;
    assign evict_data_out  = r_evict_data;

`ifdef MTF_TRACKER_STATS_EN
    logic [CNT_W-1:0] r_hit_cnt;
    logic [CNT_W-1:0] r_miss_cnt;

    // Counters saturate; flush leaves them untouched.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_hit_cnt  <= '0;
            r_miss_cnt <= '0;
        end else if (in_valid && !flush_in) begin
            if (w_hit) begin
                if (r_hit_cnt != {CNT_W{1'b1}}) begin
                    r_hit_cnt <= r_hit_cnt + 1'b1;
                end
            end else begin
                if (r_miss_cnt != {CNT_W{1'b1}}) begin
                    r_miss_cnt <= r_miss_cnt + 1'b1;
                end
            end
        end
    end

    assign hit_cnt_out  = r_hit_cnt;
    assign miss_cnt_out = r_miss_cnt;
`else
    assign hit_cnt_out  = '0;
    assign miss_cnt_out = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_mtf_tracker.sv
// ============================================================================
// Module   : tb_mtf_tracker
// Brief    : Self-checking bench for mtf_tracker against a queue-based model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mtf_tracker;

    localparam int WIDTH = 8;
    localparam int DEPTH = 4;
    localparam int IDX_W = 2;
    localparam int CNT_W = 2;

    logic                   clk_in = 1'b0;
    logic                   rst_in;
    logic                   in_valid;
    logic [WIDTH-1:0]       data_in;
    logic                   flush_in;
    logic [DEPTH*WIDTH-1:0] out;
    logic [DEPTH-1:0]       out_valid;
    logic [IDX_W:0]         count_out;
    logic                   hit_out;
    logic                   miss_out;
    logic [IDX_W-1:0]       hit_idx_out;
    logic                   evict_valid_out;
    logic [WIDTH-1:0]       evict_data_out;
    logic [CNT_W-1:0]       hit_cnt_out;
    logic [CNT_W-1:0]       miss_cnt_out;

    int n_checks = 0;
    int n_errors = 0;

    // Model: full slot contents (stale entries included) plus valid count.
    logic [WIDTH-1:0] m_q[$];
    int               m_n;
    longint           m_hc;
    longint           m_mc;

    mtf_tracker #(
        .WIDTH(WIDTH),
        .DEPTH(DEPTH),
        .IDX_W(IDX_W),
        .CNT_W(CNT_W)
    ) dut (
        .clk_in          (clk_in),
        .rst_in          (rst_in),
        .in_valid        (in_valid),
        .data_in         (data_in),
        .flush_in        (flush_in),
        .out             (out),
        .out_valid       (out_valid),
        .count_out       (count_out),
        .hit_out         (hit_out),
        .miss_out        (miss_out),
        .hit_idx_out     (hit_idx_out),
        .evict_valid_out (evict_valid_out),
        .evict_data_out  (evict_data_out),
        .hit_cnt_out     (hit_cnt_out),
        .miss_cnt_out    (miss_cnt_out)
    );

    always #5 clk_in = ~clk_in;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic step(input bit v, input logic [WIDTH-1:0] d, input bit f, input bit r);
        bit                     e_hit;
        bit                     e_miss;
        bit                     e_ev;
        int                     e_idx;
        int                     pos;
        logic [WIDTH-1:0]       e_evd;
        logic [DEPTH*WIDTH-1:0] e_out;
        longint                 lim;
        longint                 e_hc;
        longint                 e_mc;
        rst_in   = r;
        in_valid = v;
        data_in  = d;
        flush_in = f;
        @(posedge clk_in);
        #1;
        lim   = (64'd1 << CNT_W) - 1;
        e_hit = 0; e_miss = 0; e_ev = 0; e_idx = 0; e_evd = '0;
        if (r) begin
            m_q = {};
            for (int i = 0; i < DEPTH; i++) m_q.push_back('0);
            m_n = 0; m_hc = 0; m_mc = 0;
        end else if (f) begin
            m_n = 0;
        end else if (v) begin
            pos = -1;
            for (int i = 0; i < m_n; i++) begin
                if (pos < 0 && m_q[i] == d) pos = i;
            end
            if (pos >= 0) begin
                e_hit = 1;
                e_idx = pos;
                m_q.delete(pos);
                m_q.push_front(d);
                if (m_hc < lim) m_hc++;
            end else begin
                e_miss = 1;
                if (m_n == DEPTH) begin
                    e_ev  = 1;
                    e_evd = m_q[DEPTH-1];
                end
                void'(m_q.pop_back());
                m_q.push_front(d);
                if (m_n < DEPTH) m_n++;
                if (m_mc < lim) m_mc++;
            end
        end
        for (int k = 0; k < DEPTH; k++) e_out[k*WIDTH +: WIDTH] = m_q[k];
`ifdef MTF_TRACKER_STATS_EN
        e_hc = m_hc;
        e_mc = m_mc;
`else
        e_hc = 0;
        e_mc = 0;
`endif
        check("out",       64'(out),             64'(e_out));
        check("out_valid", 64'(out_valid),       (64'd1 << m_n) - 1);
        check("count",     64'(count_out),       64'(m_n));
        check("hit",       64'(hit_out),         64'(e_hit));
        check("miss",      64'(miss_out),        64'(e_miss));
        check("hit_idx",   64'(hit_idx_out),     64'(e_idx));
        check("evict_v",   64'(evict_valid_out), 64'(e_ev));
        check("evict_d",   64'(evict_data_out),  64'(e_evd));
        check("hit_cnt",   64'(hit_cnt_out),     64'(e_hc));
        check("miss_cnt",  64'(miss_cnt_out),    64'(e_mc));
    endtask

    initial begin
        rst_in = 1'b1; in_valid = 1'b0; data_in = '0; flush_in = 1'b0;
        step(0, 8'h00, 0, 1);
        step(0, 8'h00, 0, 1);
        // Fill, evict, hits at depth and at slot 0
        step(1, 8'h11, 0, 0);
        step(1, 8'h22, 0, 0);
        step(1, 8'h33, 0, 0);
        step(1, 8'h44, 0, 0);
        step(1, 8'h55, 0, 0);
        step(1, 8'h33, 0, 0);
        step(1, 8'h33, 0, 0);
        step(0, 8'h33, 0, 0);
        // Zero tag must miss against reset-cleared invalid slots
        step(0, 8'h00, 0, 1);
        step(1, 8'h00, 0, 0);
        step(1, 8'h01, 0, 0);
        step(1, 8'h02, 0, 0);
        step(1, 8'h03, 0, 0);
        // Flush beats same-cycle input; stale contents remain
        step(1, 8'h77, 1, 0);
        step(1, 8'h03, 0, 0);
        step(1, 8'h77, 0, 0);
        step(1, 8'h03, 0, 0);
        step(1, 8'h55, 0, 1);
        step(1, 8'h55, 0, 0);
        step(1, 8'h55, 0, 0);
        for (int n = 0; n < 600; n++) begin
            step($urandom_range(0, 3) != 0, 8'($urandom_range(0, 9)),
                 $urandom_range(0, 99) < 4, $urandom_range(0, 99) < 2);
        end
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
